// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch unit bus bundle (instruction memory, decoder, redirect, status)
interface fetch_unit_if #(
  parameter int PC_WIDTH = 16
);
  // Pacing and flow control from the core
  logic                step_en;
  logic                halt;

  // Instruction memory read port
  logic                imem_en;
  logic [PC_WIDTH-1:0] imem_addr;
  logic [15:0]         imem_rdata;

  // Decoder handshake
  logic [15:0]         fetchoutput;
  logic                fetch_valid;
  logic                decode_ready;

  // Redirect request
  logic                branch_valid;
  logic [PC_WIDTH-1:0] branch_target;

  // Status
  logic [PC_WIDTH-1:0] pc;
  logic [15:0]         instr_count;

  // Fetch unit side
  modport master (
    input  step_en, halt, imem_rdata, decode_ready, branch_valid, branch_target,
    output imem_en, imem_addr, fetchoutput, fetch_valid, pc, instr_count
  );

  // Environment side (memory, decoder, branch unit)
  modport slave (
    output step_en, halt, imem_rdata, decode_ready, branch_valid, branch_target,
    input  imem_en, imem_addr, fetchoutput, fetch_valid, pc, instr_count
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-entry instruction fetch stage with redirect and handshake counter
module fetch_unit #(
  parameter int          PC_WIDTH = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    FULL = 2'd2
  } state_t;

  localparam logic [PC_WIDTH-1:0] PC_INIT = PC_WIDTH'(RESET_PC);
  localparam logic [PC_WIDTH-1:0] PC_ONE  = PC_WIDTH'(1);

  state_t              state;
  logic [PC_WIDTH-1:0] pc_q;
  logic [15:0]         fetch_q;
  logic                valid_q;
  logic [15:0]         count_q;
  logic                handshake;

  // A read may only be launched from IDLE; a redirect in the same cycle wins,
  // and reset suppresses the strobe so no read is issued while held in reset.
  assign bus.imem_en   = (state == IDLE) & bus.step_en & ~bus.halt &
                         ~bus.branch_valid & ~reset;
  assign bus.imem_addr = pc_q;

  // The decoder consumes the word only when it is actually being presented.
  assign handshake = valid_q & bus.decode_ready;

  assign bus.pc          = pc_q;
  assign bus.fetchoutput = fetch_q;
  assign bus.fetch_valid = valid_q;
  assign bus.instr_count = count_q;

  // Fetch FSM with registered outputs; redirect overrides every state-local event.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state   <= IDLE;
      pc_q    <= PC_INIT;
      fetch_q <= 16'h0000;
      valid_q <= 1'b0;
      count_q <= 16'h0000;
    end else begin
      // A handshake is counted even when a redirect lands in the same cycle.
      if (handshake) begin
        count_q <= count_q + 16'h0001;
      end

      if (bus.branch_valid) begin
        // Any read in flight is dropped; fetchoutput keeps its last value.
        pc_q    <= bus.branch_target;
        valid_q <= 1'b0;
        state   <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (bus.imem_en) begin
              state <= WAIT;
            end
          end
          WAIT: begin
            // Memory data is valid one cycle after the strobe.
            fetch_q <= bus.imem_rdata;
            valid_q <= 1'b1;
            pc_q    <= pc_q + PC_ONE;
            state   <= FULL;
          end
          FULL: begin
            if (handshake) begin
              valid_q <= 1'b0;
              state   <= IDLE;
            end
          end
          default: begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

  logic clk;
  logic reset;

  fetch_unit_if #(.PC_WIDTH(16)) bus16 ();
  fetch_unit_if #(.PC_WIDTH(4))  bus4 ();

  fetch_unit #(.PC_WIDTH(16), .RESET_PC(0)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus16)
  );

  fetch_unit #(.PC_WIDTH(4), .RESET_PC(0)) dut4 (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [15:0] sb[$];
  logic [15:0] exp_count;
  logic [15:0] exp_pop;

  typedef struct {
    logic        use_branch;
    logic [15:0] target;
    logic [15:0] rdata;
    int          stall;
    logic        halt_w;
    logic [15:0] exp_addr;
    logic [15:0] exp_pc;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted instruction must match the oldest pushed word.
  always @(negedge clk) begin
    if (!reset && bus16.fetch_valid && bus16.decode_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_pop = sb.pop_front();
        check("handshake_word", {16'h0, bus16.fetchoutput}, {16'h0, exp_pop});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // From IDLE (at posedge+1): launch read, feed data in WAIT, leave in FULL.
  task automatic start_fetch(input logic [15:0] addr, input logic [15:0] data, input logic halt_w);
    bus16.step_en = 1'b1;
    bus16.halt    = 1'b0;
    @(negedge clk);
    check("imem_en_idle", {31'h0, bus16.imem_en}, 32'd1);
    check("imem_addr", {16'h0, bus16.imem_addr}, {16'h0, addr});
    tick;
    bus16.step_en    = 1'b1;
    bus16.halt       = halt_w;
    bus16.imem_rdata = data;
    sb.push_back(data);
    @(negedge clk);
    check("imem_en_wait", {31'h0, bus16.imem_en}, 32'd0);
    check("valid_wait", {31'h0, bus16.fetch_valid}, 32'd0);
    tick;
    bus16.step_en    = 1'b0;
    bus16.halt       = 1'b0;
    bus16.imem_rdata = ~data;
  endtask

  task automatic hold_full(input int n, input logic [15:0] data);
    for (int i = 0; i < n; i++) begin
      bus16.decode_ready = 1'b0;
      bus16.step_en      = 1'b1;
      bus16.imem_rdata   = data ^ 16'(i + 1);
      @(negedge clk);
      check("hold_valid", {31'h0, bus16.fetch_valid}, 32'd1);
      check("hold_word", {16'h0, bus16.fetchoutput}, {16'h0, data});
      check("hold_no_en", {31'h0, bus16.imem_en}, 32'd0);
      tick;
    end
    bus16.step_en = 1'b0;
  endtask

  task automatic handshake;
    bus16.decode_ready = 1'b1;
    bus16.step_en      = 1'b0;
    exp_count          = exp_count + 16'h0001;
    tick;
    bus16.decode_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    if (v.use_branch) begin
      bus16.branch_valid  = 1'b1;
      bus16.branch_target = v.target;
      tick;
      bus16.branch_valid  = 1'b0;
    end
    start_fetch(v.exp_addr, v.rdata, v.halt_w);
    hold_full(v.stall, v.rdata);
    handshake;
    @(negedge clk);
    check("vec_pc", {16'h0, bus16.pc}, {16'h0, v.exp_pc});
    check("vec_count", {16'h0, bus16.instr_count}, {16'h0, exp_count});
    check("vec_valid_clr", {31'h0, bus16.fetch_valid}, 32'd0);
    check("vec_word_kept", {16'h0, bus16.fetchoutput}, {16'h0, v.rdata});
    tick;
  endtask

  initial begin
    vecs[0] = '{1'b0, 16'h0000, 16'h1234, 0, 1'b0, 16'h0000, 16'h0001};
    vecs[1] = '{1'b0, 16'h0000, 16'hABCD, 5, 1'b0, 16'h0001, 16'h0002};
    vecs[2] = '{1'b1, 16'h0200, 16'h5555, 1, 1'b1, 16'h0200, 16'h0201};
    vecs[3] = '{1'b1, 16'hFFFF, 16'h8001, 0, 1'b0, 16'hFFFF, 16'h0000};
    vecs[4] = '{1'b0, 16'h0000, 16'h7E7E, 2, 1'b1, 16'h0000, 16'h0001};

    exp_count = 16'h0000;
    reset = 1'b1;
    bus16.step_en = 1'b1; bus16.halt = 1'b0; bus16.imem_rdata = 16'h0;
    bus16.decode_ready = 1'b0; bus16.branch_valid = 1'b0; bus16.branch_target = 16'h0;
    bus4.step_en = 1'b0; bus4.halt = 1'b0; bus4.imem_rdata = 16'h0;
    bus4.decode_ready = 1'b0; bus4.branch_valid = 1'b0; bus4.branch_target = 4'h0;

    // Reset: strobe held low even with step_en high
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_imem_en", {31'h0, bus16.imem_en}, 32'd0);
      tick;
    end
    reset = 1'b0;
    bus16.step_en = 1'b0;
    @(negedge clk);
    check("rst_pc", {16'h0, bus16.pc}, 32'h0);
    check("rst_valid", {31'h0, bus16.fetch_valid}, 32'd0);
    check("rst_count", {16'h0, bus16.instr_count}, 32'h0);
    check("rst_word", {16'h0, bus16.fetchoutput}, 32'h0);
    tick;

    for (int k = 0; k < 5; k++) begin
      run_vec(vecs[k]);
    end

    // Redirect while the read is in flight: data dropped, next fetch at target
    bus16.step_en = 1'b1;
    @(negedge clk);
    check("brw_en", {31'h0, bus16.imem_en}, 32'd1);
    tick;
    bus16.step_en = 1'b0;
    bus16.branch_valid = 1'b1; bus16.branch_target = 16'h0040; bus16.imem_rdata = 16'hDEAD;
    tick;
    bus16.branch_valid = 1'b0;
    @(negedge clk);
    check("brw_valid", {31'h0, bus16.fetch_valid}, 32'd0);
    check("brw_word", {16'h0, bus16.fetchoutput}, 32'h7E7E);
    check("brw_pc", {16'h0, bus16.pc}, 32'h0040);
    tick;
    @(negedge clk);
    check("brw_valid_later", {31'h0, bus16.fetch_valid}, 32'd0);
    tick;
    start_fetch(16'h0040, 16'h1111, 1'b0);
    handshake;
    @(negedge clk);
    check("brw_pc_after", {16'h0, bus16.pc}, 32'h0041);
    check("brw_count", {16'h0, bus16.instr_count}, {16'h0, exp_count});
    tick;

    // Halt in IDLE blocks the strobe
    bus16.halt = 1'b1;
    bus16.step_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("halt_no_en", {31'h0, bus16.imem_en}, 32'd0);
      tick;
    end
    bus16.halt = 1'b0;
    bus16.step_en = 1'b0;
    @(negedge clk);
    check("halt_pc", {16'h0, bus16.pc}, 32'h0041);
    check("halt_valid", {31'h0, bus16.fetch_valid}, 32'd0);
    tick;

    // Handshake and redirect in the same FULL cycle
    start_fetch(16'h0041, 16'h2222, 1'b0);
    bus16.decode_ready = 1'b1;
    bus16.branch_valid = 1'b1; bus16.branch_target = 16'h0100;
    exp_count = exp_count + 16'h0001;
    tick;
    bus16.decode_ready = 1'b0; bus16.branch_valid = 1'b0;
    @(negedge clk);
    check("bhs_pc", {16'h0, bus16.pc}, 32'h0100);
    check("bhs_valid", {31'h0, bus16.fetch_valid}, 32'd0);
    check("bhs_count", {16'h0, bus16.instr_count}, {16'h0, exp_count});
    check("bhs_word", {16'h0, bus16.fetchoutput}, 32'h2222);
    tick;

    // Reset while FULL
    start_fetch(16'h0100, 16'h3333, 1'b0);
    hold_full(1, 16'h3333);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    sb.delete();
    exp_count = 16'h0000;
    @(negedge clk);
    check("rstf_valid", {31'h0, bus16.fetch_valid}, 32'd0);
    check("rstf_pc", {16'h0, bus16.pc}, 32'h0);
    check("rstf_count", {16'h0, bus16.instr_count}, 32'h0);
    check("rstf_word", {16'h0, bus16.fetchoutput}, 32'h0);
    tick;

    // Reset during WAIT beats a simultaneous redirect and abandons the read
    bus16.step_en = 1'b1;
    @(negedge clk);
    check("rstw_en", {31'h0, bus16.imem_en}, 32'd1);
    tick;
    reset = 1'b1;
    bus16.branch_valid = 1'b1; bus16.branch_target = 16'h0500; bus16.imem_rdata = 16'h9999;
    tick;
    reset = 1'b0;
    bus16.branch_valid = 1'b0; bus16.step_en = 1'b0;
    @(negedge clk);
    check("rstw_pc", {16'h0, bus16.pc}, 32'h0);
    check("rstw_valid", {31'h0, bus16.fetch_valid}, 32'd0);
    check("rstw_word", {16'h0, bus16.fetchoutput}, 32'h0);
    tick;
    @(negedge clk);
    check("rstw_valid_later", {31'h0, bus16.fetch_valid}, 32'd0);
    tick;

    // Narrow PC wraps from 4'hF to 0
    bus4.branch_valid = 1'b1; bus4.branch_target = 4'hF;
    tick;
    bus4.branch_valid = 1'b0;
    bus4.step_en = 1'b1;
    @(negedge clk);
    check("w4_addr", {28'h0, bus4.imem_addr}, 32'hF);
    check("w4_en", {31'h0, bus4.imem_en}, 32'd1);
    tick;
    bus4.step_en = 1'b0;
    bus4.imem_rdata = 16'h4444;
    tick;
    @(negedge clk);
    check("w4_pc", {28'h0, bus4.pc}, 32'h0);
    check("w4_valid", {31'h0, bus4.fetch_valid}, 32'd1);
    check("w4_word", {16'h0, bus4.fetchoutput}, 32'h4444);
    tick;
    bus4.decode_ready = 1'b1;
    tick;
    bus4.decode_ready = 1'b0;
    @(negedge clk);
    check("w4_count", {16'h0, bus4.instr_count}, 32'd1);
    check("w4_valid_clr", {31'h0, bus4.fetch_valid}, 32'd0);

    check("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
